log_merge_arbiter: RTL and testbench
====================================

# log_merge_arbiter

Merges the logging streams of NUM_CH channel loggers into one record stream feeding the log storage backend. Each channel's pipelined logb/loge traffic is fire-and-forget: it carries no ready signal, so it is absorbed into a per-channel FIFO. The FIFOs are drained round-robin into a single valid/ready output. The block generates each channel's logb_almful with enough slack to cover the full almful→logger→logb pipeline round trip.

## Interface
- NUM_CH, 4, number of logged channels (2..8)
- DATA_WIDTH, 32, logb payload width
- PIPE_DEPTH, 4, register stages on each direction between logger and this block
- FIFO_DEPTH, 32, entries per channel FIFO; power of two; must exceed ALMFUL_SLACK
- ALMFUL_SLACK (localparam), 2*(2*PIPE_DEPTH+2), headroom reserved above the almful threshold
- clk  in  1  clock
- rstn  in  1  reset; asynchronous assert, active-low, released synchronously by the system
- logb_valid  in  NUM_CH  per-channel begin-record strobe
- logb_data  in  NUM_CH*DATA_WIDTH  per-channel payload; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- loge_valid  in  NUM_CH  per-channel end-record strobe; no payload
- logb_almful  out  NUM_CH  per-channel backpressure to the loggers; registered
- out_valid  out  1  merged record valid
- out_ready  in  1  backend accepts the record
- out_data  out  DATA_WIDTH  payload; 0 for end records
- out_ch  out  $clog2(NUM_CH)  source channel
- out_end  out  1  1 = end record, 0 = begin record
- overflow  out  NUM_CH  sticky; set when a push hits a full FIFO

## Operation
- FIFO entry: {end flag, data}. Each FIFO accepts up to 2 pushes per cycle.
- Push order within one cycle when both strobes are high: logb entry first, then loge entry.
- Push into a full FIFO: the entry is dropped and overflow[i] is set. Only reset clears it.
- Occupancy count: width $clog2(FIFO_DEPTH)+1. Each cycle, count += pushes − pop, with pushes in {0,1,2} and pop in {0,1}.
- Pointers wrap modulo FIFO_DEPTH.
- logb_almful[i] is registered. It is 1 when next-cycle count[i] ≥ FIFO_DEPTH − ALMFUL_SLACK.
- Arbiter uses round-robin with a last-grant pointer (reset value NUM_CH−1).
  - Search starts at last+1 and wraps.
  - Only non-empty FIFOs are eligible.
  - The pointer updates only on an actual pop.
- Output register states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- Transitions:
  - In EMPTY, or in FULL with out_ready = 1, a pop occurs if any FIFO is non-empty. The popped entry loads the output register.
  - If no FIFO is non-empty, FULL with out_ready = 1 goes to EMPTY.
  - FULL with out_ready = 0 holds out_data, out_ch and out_end stable.
- Reset (async, any time):
  - Pointers, counts, overflow, last-grant pointer and output state clear.
  - logb_almful = 0, out_valid = 0, out_data = 0, out_ch = 0, out_end = 0.
  - FIFO RAM contents are not reset.
  - In-flight entries are lost.

## Timing
- An entry pushed at edge t is visible to the arbiter in cycle t+1. It is popped at edge t+1 at the earliest, so out_valid rises in cycle t+2.
- Minimum latency: 2 cycles. There is no bypass of an empty FIFO.
- Throughput: 1 record/cycle total with out_ready held high.
- almful reflects occupancy 1 cycle later. The logger sees it PIPE_DEPTH cycles after that.
- ALMFUL_SLACK covers worst-case arrivals after assertion: (2*PIPE_DEPTH+2) cycles × 2 entries.
- Push and pop on the same FIFO in the same cycle are both honoured. A full FIFO popping and receiving 1 push stays full without overflow.

## Configuration
- LOG_MERGE_STATS_EN defined:
  - Adds output stat_records[31:0]: total records accepted at the output (out_valid && out_ready), wrapping at 2^32.
  - Adds output stat_maxocc[$clog2(FIFO_DEPTH):0]: highest occupancy seen across all FIFOs since reset.
  - Both reset to 0.
- Undefined: neither port exists and no counter logic is synthesized.

## Test plan
- Single channel: ch2 logb_valid with data 0xA5, then loge next cycle, out_ready = 1 → out {ch2, end 0, 0xA5} valid in cycle t+2, then {ch2, end 1, 0} in cycle t+3.
- Same-cycle logb+loge on ch0 with data 7 → logb record precedes loge record; count reaches 2 and then drains.
- All 4 channels push every cycle for 8 cycles, out_ready = 1 → grants ch0, ch1, ch2, ch3, ch0, …; no overflow; every channel's records in order.
- out_ready = 0 while ch1 fills → logb_almful[1] rises in the cycle after count reaches 12 (32−20).
  - With the logger honouring almful through PIPE_DEPTH = 4, overflow[1] stays 0.
- Ignore almful and push 33 entries to ch3 with out_ready = 0 → 33rd entry dropped, overflow[3] = 1 and held until rstn.
- Assert rstn = 0 mid-stream with out_valid = 1 → out_valid and almful go 0 immediately without waiting for clk; after release, no stale records appear.

Source files
------------

// File: rtl/log_merge_arbiter_if.sv
// Signal bundle between the channel loggers / log backend and log_merge_arbiter.
// The slave modport is the merge block; the master modport is the loggers plus backend.
interface log_merge_arbiter_if #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            logb_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] logb_data;
    logic [NUM_CH-1:0]            loge_valid;
    logic [NUM_CH-1:0]            logb_almful;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_end;
    logic [NUM_CH-1:0]            overflow;

    modport slave (
        input  logb_valid,
        input  logb_data,
        input  loge_valid,
        input  out_ready,
        output logb_almful,
        output out_valid,
        output out_data,
        output out_ch,
        output out_end,
        output overflow
    );

    modport master (
        output logb_valid,
        output logb_data,
        output loge_valid,
        output out_ready,
        input  logb_almful,
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_end,
        input  overflow
    );
endinterface

// File: rtl/log_merge_arbiter.sv
// Merges NUM_CH fire-and-forget logb/loge streams through per-channel FIFOs into one
// round-robin valid/ready record stream. Optional counters under LOG_MERGE_STATS_EN.
module log_merge_arbiter #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PIPE_DEPTH = 4,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rstn,
    log_merge_arbiter_if.slave            bus
`ifdef LOG_MERGE_STATS_EN
    ,
    output logic [31:0]                   stat_records,
    output logic [$clog2(FIFO_DEPTH):0]   stat_maxocc
`endif
);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned CW           = AW + 1;
    localparam int unsigned CHW          = $clog2(NUM_CH);
    localparam int unsigned EW           = DATA_WIDTH + 1;
    localparam int unsigned ALMFUL_SLACK = 2 * (2 * PIPE_DEPTH + 2);
    localparam int unsigned ALMFUL_THR   = FIFO_DEPTH - ALMFUL_SLACK;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } ostate_e;

    ostate_e               state_q;
    ostate_e               state_d;

    logic [EW-1:0]         mem      [NUM_CH][FIFO_DEPTH];
    logic [AW-1:0]         wptr     [NUM_CH];
    logic [AW-1:0]         rptr     [NUM_CH];
    logic [CW-1:0]         cnt      [NUM_CH];
    logic [CW-1:0]         cnt_nxt  [NUM_CH];
    logic [CW-1:0]         space    [NUM_CH];

    logic [NUM_CH-1:0]     acc_b;
    logic [NUM_CH-1:0]     acc_e;
    logic [NUM_CH-1:0]     drop;
    logic [NUM_CH-1:0]     nonempty;
    logic [NUM_CH-1:0]     pop;

    logic [CHW-1:0]        last_grant;
    logic [CHW-1:0]        grant_ch;
    logic                  grant_vld;
    logic                  pop_en;
    logic [EW-1:0]         rd_entry;

    logic [NUM_CH-1:0]     almful_q;
    logic [NUM_CH-1:0]     overflow_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CHW-1:0]        ch_q;
    logic                  end_q;

    always_comb begin
        nonempty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            nonempty[i] = (cnt[i] != '0);
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            if (!grant_vld && nonempty[CHW'((32'(last_grant) + k) % NUM_CH)]) begin
                grant_vld = 1'b1;
                grant_ch  = CHW'((32'(last_grant) + k) % NUM_CH);
            end
        end
    end

    assign rd_entry = mem[grant_ch][rptr[grant_ch]];

    // Output register FSM: state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_EMPTY: if (grant_vld)                      state_d = S_FULL;
            S_FULL:  if (bus.out_ready && !grant_vld)    state_d = S_EMPTY;
        endcase
    end

    // Output register FSM: pop decode (a free or draining slot takes the granted entry).
    always_comb begin
        pop_en = grant_vld && ((state_q == S_EMPTY) || bus.out_ready);
        pop    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = pop_en && (grant_ch == CHW'(i));
        end
    end

    // Push acceptance: logb takes the first free slot, loge the next; a same-cycle pop frees one.
    always_comb begin
        acc_b = '0;
        acc_e = '0;
        drop  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            space[i]   = CW'(FIFO_DEPTH) - cnt[i] + CW'(pop[i]);
            acc_b[i]   = bus.logb_valid[i] && (space[i] != '0);
            acc_e[i]   = bus.loge_valid[i] && (space[i] > CW'(acc_b[i]));
            drop[i]    = (bus.logb_valid[i] && !acc_b[i]) || (bus.loge_valid[i] && !acc_e[i]);
            cnt_nxt[i] = cnt[i] + CW'(acc_b[i]) + CW'(acc_e[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_b[i]) begin
                mem[i][wptr[i]] <= {1'b0, bus.logb_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
            if (acc_e[i]) begin
                mem[i][wptr[i] + AW'(acc_b[i])] <= {1'b1, {DATA_WIDTH{1'b0}}};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            almful_q   <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wptr[i]     <= wptr[i] + AW'(acc_b[i]) + AW'(acc_e[i]);
                cnt[i]      <= cnt_nxt[i];
                almful_q[i] <= (cnt_nxt[i] >= CW'(ALMFUL_THR));
                if (pop[i]) begin
                    rptr[i] <= rptr[i] + AW'(1);
                end
                if (drop[i]) begin
                    overflow_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= CHW'(NUM_CH - 1);
            data_q     <= '0;
            ch_q       <= '0;
            end_q      <= 1'b0;
        end else if (pop_en) begin
            last_grant <= grant_ch;
            data_q     <= rd_entry[DATA_WIDTH-1:0];
            ch_q       <= grant_ch;
            end_q      <= rd_entry[DATA_WIDTH];
        end
    end

    assign bus.logb_almful = almful_q;
    assign bus.overflow    = overflow_q;
    assign bus.out_valid   = (state_q == S_FULL);
    assign bus.out_data    = data_q;
    assign bus.out_ch      = ch_q;
    assign bus.out_end     = end_q;

`ifdef LOG_MERGE_STATS_EN
    logic [CW-1:0] occ_max_c;

    always_comb begin
        occ_max_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt[i] > occ_max_c) begin
                occ_max_c = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_records <= '0;
            stat_maxocc  <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                stat_records <= stat_records + 32'd1;
            end
            if (occ_max_c > stat_maxocc) begin
                stat_maxocc <= occ_max_c;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_log_merge_arbiter.sv
// Directed bench for log_merge_arbiter: vector table plus multi-cycle sequences for
// round-robin merge, almful threshold, overflow and asynchronous reset.
module tb_log_merge_arbiter;
    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 32;
    localparam int unsigned PD  = 4;
    localparam int unsigned FD  = 32;

    typedef struct {
        logic [3:0]  lb;
        logic [3:0]  le;
        logic [31:0] d;
        logic [1:0]  dch;
        logic        rdy;
        logic        ev;
        logic [1:0]  ech;
        logic        ee;
        logic [31:0] ed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    int          total = 0;
    int          bad   = 0;
    vec_t        tbl [14];
    int          got;
    int          seq;
    logic [PD-1:0] alm_hist;
    logic [PD-1:0] pipe_v;
    int          pipe_d [PD];

    log_merge_arbiter_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

`ifdef LOG_MERGE_STATS_EN
    logic [31:0] stat_records;
    logic [5:0]  stat_maxocc;
`endif

    log_merge_arbiter #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef LOG_MERGE_STATS_EN
        ,
        .stat_records (stat_records),
        .stat_maxocc  (stat_maxocc)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.logb_valid = '0;
        bus.loge_valid = '0;
        bus.logb_data  = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{4'b0100, 4'b0000, 32'hA5, 2'd2, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[1]  = '{4'b0000, 4'b0100, 32'h00, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0, 32'hA5};
        tbl[2]  = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b1, 2'd2, 1'b1, 32'h0};
        tbl[3]  = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[4]  = '{4'b0001, 4'b0001, 32'h07, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[5]  = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h7};
        tbl[6]  = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 32'h0};
        tbl[7]  = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[8]  = '{4'b0010, 4'b0000, 32'h11, 2'd1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0};
        tbl[9]  = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h11};
        tbl[10] = '{4'b1000, 4'b0000, 32'h33, 2'd3, 1'b0, 1'b1, 2'd1, 1'b0, 32'h11};
        tbl[11] = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h11};
        tbl[12] = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h33};
        tbl[13] = '{4'b0000, 4'b0000, 32'h00, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0};

        rstn = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        repeat (3) step();
        chk("rst_valid",  64'(bus.out_valid),   64'd0);
        chk("rst_almful", 64'(bus.logb_almful), 64'd0);
        chk("rst_ovf",    64'(bus.overflow),    64'd0);
        chk("rst_data",   64'(bus.out_data),    64'd0);
        chk("rst_ch",     64'(bus.out_ch),      64'd0);
        chk("rst_end",    64'(bus.out_end),     64'd0);
        rstn = 1'b1;
        step();

        // Single-record latency, same-cycle logb+loge order, and hold under out_ready=0.
        for (int r = 0; r < 14; r++) begin
            idle();
            bus.out_ready  = tbl[r].rdy;
            bus.logb_valid = tbl[r].lb;
            bus.loge_valid = tbl[r].le;
            bus.logb_data[int'(tbl[r].dch)*DW +: DW] = tbl[r].d;
            step();
            chk($sformatf("vec%0d_valid", r), 64'(bus.out_valid), 64'(tbl[r].ev));
            if (tbl[r].ev) begin
                chk($sformatf("vec%0d_ch", r),   64'(bus.out_ch),   64'(tbl[r].ech));
                chk($sformatf("vec%0d_end", r),  64'(bus.out_end),  64'(tbl[r].ee));
                chk($sformatf("vec%0d_data", r), 64'(bus.out_data), 64'(tbl[r].ed));
            end
            chk($sformatf("vec%0d_ovf", r), 64'(bus.overflow), 64'd0);
        end

        // All channels push for 8 cycles: strict ch0..ch3 rotation, per-channel order kept.
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 80; c++) begin
            if (bus.out_valid) begin
                chk("rr_ch",   64'(bus.out_ch),   64'(got % 4));
                chk("rr_data", 64'(bus.out_data), 64'((got % 4) * 256 + got / 4));
                chk("rr_end",  64'(bus.out_end),  64'd0);
                got++;
            end
            idle();
            if (c < 8) begin
                bus.logb_valid = 4'hF;
                for (int ch = 0; ch < 4; ch++) begin
                    bus.logb_data[ch*DW +: DW] = 32'(ch * 256 + c);
                end
            end
            step();
        end
        chk("rr_count", 64'(got), 64'd32);
        chk("rr_ovf",   64'(bus.overflow), 64'd0);

        // ch1 fills with out_ready=0: almful rises once occupancy reaches 12.
        idle();
        bus.out_ready = 1'b0;
        seq = 0;
        for (int k = 1; k <= 13; k++) begin
            idle();
            bus.logb_valid = 4'b0010;
            seq++;
            bus.logb_data[63:32] = 32'(seq);
            step();
            chk($sformatf("almful_k%0d", k), 64'(bus.logb_almful[1]), 64'(k >= 13));
        end
        // Logger honouring almful through PD stages each way.
        alm_hist = '0;
        pipe_v   = '0;
        for (int s = 0; s < PD; s++) pipe_d[s] = 0;
        for (int c = 0; c < 40; c++) begin
            idle();
            if (pipe_v[PD-1]) begin
                bus.logb_valid[1]    = 1'b1;
                bus.logb_data[63:32] = 32'(pipe_d[PD-1]);
            end
            for (int s = PD - 1; s > 0; s--) begin
                pipe_v[s] = pipe_v[s-1];
                pipe_d[s] = pipe_d[s-1];
            end
            pipe_v[0] = !alm_hist[PD-1];
            if (pipe_v[0]) begin
                seq++;
                pipe_d[0] = seq;
            end
            step();
            alm_hist = {alm_hist[PD-2:0], bus.logb_almful[1]};
        end
        chk("alm_ovf1",  64'(bus.overflow[1]),    64'd0);
        chk("alm_held",  64'(bus.logb_almful[1]), 64'd1);
        idle();
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100; c++) begin
            if (bus.out_valid) begin
                chk("alm_ch",   64'(bus.out_ch),   64'd1);
                chk("alm_data", 64'(bus.out_data), 64'(got + 1));
                got++;
            end
            step();
        end
        chk("alm_count",   64'(got), 64'(seq));
        chk("alm_release", 64'(bus.logb_almful[1]), 64'd0);

        // Output register held by ch0, then 33 pushes to ch3: the 33rd is dropped.
        idle();
        bus.out_ready  = 1'b0;
        bus.logb_valid = 4'b0001;
        bus.logb_data[31:0] = 32'hC0;
        step();
        for (int k = 1; k <= 33; k++) begin
            idle();
            bus.logb_valid = 4'b1000;
            bus.logb_data[127:96] = 32'(k);
            step();
            chk($sformatf("ovf_k%0d", k), 64'(bus.overflow[3]), 64'(k >= 33));
        end
        chk("ovf_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("ovf_hold_ch",    64'(bus.out_ch),    64'd0);
        idle();
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 120; c++) begin
            if (bus.out_valid) begin
                chk("ovf_ch",   64'(bus.out_ch),   (got == 0) ? 64'd0 : 64'd3);
                chk("ovf_data", 64'(bus.out_data), (got == 0) ? 64'hC0 : 64'(got));
                got++;
            end
            step();
        end
        chk("ovf_count",  64'(got), 64'd33);
        chk("ovf_sticky", 64'(bus.overflow), 64'b1000);

        // Asynchronous reset in mid-stream with a record pending and almful asserted.
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            idle();
            bus.logb_valid = 4'b0100;
            bus.logb_data[95:64] = 32'(32'h200 + k);
            step();
        end
        idle();
        chk("pre_rst_valid",  64'(bus.out_valid),      64'd1);
        chk("pre_rst_almful", 64'(bus.logb_almful[2]), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid",  64'(bus.out_valid),   64'd0);
        chk("arst_almful", 64'(bus.logb_almful), 64'd0);
        chk("arst_ovf",    64'(bus.overflow),    64'd0);
        chk("arst_data",   64'(bus.out_data),    64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("post_rst_valid%0d", c), 64'(bus.out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
